// File: rtl/overture_pkg.sv
// Shared definitions for the Overture sequencer: FSM states, opcode classes,
// special register indices and the condition codes used by the evaluator.
package overture_pkg;

    typedef enum logic [2:0] {
        ST_FETCH    = 3'd0,
        ST_EXEC     = 3'd1,
        ST_WAIT_IN  = 3'd2,
        ST_WAIT_OUT = 3'd3,
        ST_HALT     = 3'd4
    } state_t;

    // Opcode classes decoded from instr[7:6]
    localparam logic [1:0] IMM  = 2'b00;
    localparam logic [1:0] CALC = 2'b01;
    localparam logic [1:0] COPY = 2'b10;
    localparam logic [1:0] COND = 2'b11;

    localparam int         NUM_REGS   = 6;
    localparam logic [2:0] IO_REG     = 3'd6;
    localparam logic [2:0] RSVD_REG   = 3'd7;
    localparam logic [7:0] HALT_INSTR = 8'hC0;

    // Condition codes; every test compares r3 against zero (signed)
    localparam logic [2:0] COND_NEVER = 3'd0;
    localparam logic [2:0] COND_EQ    = 3'd1;
    localparam logic [2:0] COND_LT    = 3'd2;
    localparam logic [2:0] COND_LE    = 3'd3;
    localparam logic [2:0] COND_ALWAYS = 3'd4;
    localparam logic [2:0] COND_NE    = 3'd5;
    localparam logic [2:0] COND_GE    = 3'd6;
    localparam logic [2:0] COND_GT    = 3'd7;

    // Field view of an instruction byte. For conditions, dst carries cond_sel;
    // for compute, dst carries the ALU opcode.
    typedef struct packed {
        logic [1:0] cls;
        logic [2:0] src;
        logic [2:0] dst;
    } instr_t;

    // True for indices that name a real register (r0-r5)
    function automatic logic is_gpr(input logic [2:0] idx);
        return (idx < IO_REG);
    endfunction

endpackage

// File: rtl/overture_condition.sv
// Condition evaluator: tests r3 (as a signed byte) against zero for the
// selected condition code.
module overture_condition
    import overture_pkg::*;
(
    input  logic [7:0] r3,
    input  logic [2:0] cond_sel,
    output logic       cond_met
);

    logic is_zero;
    logic is_neg;

    assign is_zero = (r3 == 8'h00);
    assign is_neg  = r3[7];

    // Decode the condition code into a single met/not-met flag
    always_comb begin
        cond_met = 1'b0;
        case (cond_sel)
            COND_NEVER:  cond_met = 1'b0;
            COND_EQ:     cond_met = is_zero;
            COND_LT:     cond_met = is_neg;
            COND_LE:     cond_met = is_neg | is_zero;
            COND_ALWAYS: cond_met = 1'b1;
            COND_NE:     cond_met = ~is_zero;
            COND_GE:     cond_met = ~is_neg;
            COND_GT:     cond_met = ~is_neg & ~is_zero;
            default:     cond_met = 1'b0;
        endcase
    end

endmodule

// File: rtl/overture_sequencer.sv
// Overture fetch/execute sequencer: owns the PC and r0-r5, decodes each
// instruction byte and handshakes with program memory and the I/O ports.
// Optional feature macro: OVERTURE_SEQ_HALT_EN (8'hC0 halts the core).
module overture_sequencer
    import overture_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       imem_req,
    output logic [7:0] imem_addr,
    input  logic       imem_ack,
    input  logic [7:0] imem_data,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] alu_op,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_result,
    output logic       halted
);

    state_t                     state, state_nxt;
    logic [7:0]                 pc;
    instr_t                     ir;
    logic [NUM_REGS-1:0][7:0]   regs;
    logic                       started;

    // Datapath control produced by the FSM
    logic                       pc_inc;
    logic                       pc_load;
    logic                       ir_load;
    logic                       rf_we;
    logic [2:0]                 rf_waddr;
    logic [7:0]                 rf_wdata;
    logic                       out_load;
    logic [7:0]                 out_wdata;

    logic [7:0]                 src_val;
    logic                       cond_met;
    logic                       halt_hit;

    overture_condition u_cond (
        .r3       (regs[3]),
        .cond_sel (ir.dst),
        .cond_met (cond_met)
    );

`ifdef OVERTURE_SEQ_HALT_EN
    assign halt_hit = (ir == instr_t'(HALT_INSTR));
    assign halted   = (state == ST_HALT);
`else
    assign halt_hit = 1'b0;
    assign halted   = 1'b0;
`endif

    // Request is held off for the first cycle after reset release so the
    // memory never sees a fetch while the core is still in reset.
    assign imem_req  = started && (state == ST_FETCH);
    assign imem_addr = pc;
    assign in_ready  = (state == ST_WAIT_IN);
    assign out_valid = (state == ST_WAIT_OUT);
    assign alu_op    = ir.dst;
    assign alu_a     = regs[1];
    assign alu_b     = regs[2];

    // Copy source operand; the reserved index reads as zero
    always_comb begin
        src_val = 8'h00;
        if (is_gpr(ir.src))
            src_val = regs[ir.src];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_FETCH;
        else        state <= state_nxt;
    end

    // Next-state and datapath control decode
    always_comb begin
        state_nxt = state;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        ir_load   = 1'b0;
        rf_we     = 1'b0;
        rf_waddr  = 3'd0;
        rf_wdata  = 8'h00;
        out_load  = 1'b0;
        out_wdata = 8'h00;

        case (state)
            ST_FETCH: begin
                if (imem_req && imem_ack) begin
                    ir_load   = 1'b1;
                    state_nxt = ST_EXEC;
                end
            end

            ST_EXEC: begin
                state_nxt = ST_FETCH;
                case (ir.cls)
                    IMM: begin
                        rf_we    = 1'b1;
                        rf_waddr = 3'd0;
                        rf_wdata = {2'b00, ir.src, ir.dst};
                        pc_inc   = 1'b1;
                    end
                    CALC: begin
                        rf_we    = 1'b1;
                        rf_waddr = 3'd3;
                        rf_wdata = alu_result;
                        pc_inc   = 1'b1;
                    end
                    COPY: begin
                        if (ir.src == IO_REG) begin
                            state_nxt = ST_WAIT_IN;
                        end else if (ir.dst == IO_REG) begin
                            out_load  = 1'b1;
                            out_wdata = src_val;
                            state_nxt = ST_WAIT_OUT;
                        end else begin
                            // dst 7 silently discards the write
                            rf_we    = is_gpr(ir.dst);
                            rf_waddr = ir.dst;
                            rf_wdata = src_val;
                            pc_inc   = 1'b1;
                        end
                    end
                    default: begin
                        // COND: halt leaves the PC on the C0 itself
                        if (halt_hit)
                            state_nxt = ST_HALT;
                        else if (cond_met)
                            pc_load = 1'b1;
                        else
                            pc_inc = 1'b1;
                    end
                endcase
            end

            ST_WAIT_IN: begin
                if (in_valid) begin
                    if (ir.dst == IO_REG) begin
                        out_load  = 1'b1;
                        out_wdata = in_data;
                        state_nxt = ST_WAIT_OUT;
                    end else begin
                        rf_we     = is_gpr(ir.dst);
                        rf_waddr  = ir.dst;
                        rf_wdata  = in_data;
                        pc_inc    = 1'b1;
                        state_nxt = ST_FETCH;
                    end
                end
            end

            ST_WAIT_OUT: begin
                if (out_ready) begin
                    pc_inc    = 1'b1;
                    state_nxt = ST_FETCH;
                end
            end

            ST_HALT: state_nxt = ST_HALT;

            default: state_nxt = ST_FETCH;
        endcase
    end

    // Gate for the first fetch request after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) started <= 1'b0;
        else        started <= 1'b1;
    end

    // PC update; 8-bit wraparound is intentional
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       pc <= RESET_PC;
        else if (pc_load) pc <= regs[0];
        else if (pc_inc)  pc <= pc + 8'd1;
    end

    // Instruction register, loaded on the fetch handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       ir <= '0;
        else if (ir_load) ir <= instr_t'(imem_data);
    end

    // Register file write port (single writer per cycle)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     regs <= '0;
        else if (rf_we) regs[rf_waddr] <= rf_wdata;
    end

    // Output port data; held stable for the whole WAIT_OUT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        out_data <= 8'h00;
        else if (out_load) out_data <= out_wdata;
    end

endmodule

// File: tb/tb_overture_sequencer.sv
// Directed bench for overture_sequencer: small program memory with a
// configurable ack delay, an add-only ALU model, and manual I/O handshakes.
module tb_overture_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_data;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_result;
    logic       halted;

    logic [7:0] mem [0:255];
    int         ack_wait = 0;
    int         wcnt = 0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    overture_sequencer #(.RESET_PC(8'h00)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .halted     (halted)
    );

    assign imem_data  = mem[imem_addr];
    assign imem_ack   = imem_req && (wcnt >= ack_wait);
    assign alu_result = alu_a + alu_b;

    // Memory wait-state counter: cycles a request has been pending
    always @(posedge clk) begin
        if (!imem_req || imem_ack) wcnt <= 0;
        else                       wcnt <= wcnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a fetch handshake, check its address, step into EXEC
    task automatic wait_fetch(input logic [7:0] exp, input string tag);
        logic got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (imem_req && imem_ack) got = 1'b1;
            else tick();
        end
        chk({tag, "_seen"}, {31'd0, got}, 32'd1);
        if (got) begin
            chk(tag, {24'd0, imem_addr}, {24'd0, exp});
            tick();
        end
    endtask

    initial begin
        int n_in;
        int n_out;
        int n_req;
        logic [7:0] seq [7];

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h05; mem[8'h01] = 8'hC4;
        mem[8'h05] = 8'h03; mem[8'h06] = 8'h81; mem[8'h07] = 8'h04;
        mem[8'h08] = 8'h82; mem[8'h09] = 8'h44; mem[8'h0A] = 8'h9E;
        mem[8'h0B] = 8'hB6; mem[8'h0C] = 8'hB3; mem[8'h0D] = 8'h20;
        mem[8'h0E] = 8'hC2;
        mem[8'h20] = 8'hC6; mem[8'h21] = 8'h30; mem[8'h22] = 8'hC5;
        mem[8'h30] = 8'hC1; mem[8'h31] = 8'h9E; mem[8'h32] = 8'hB0;
        mem[8'h33] = 8'hC4; mem[8'hFF] = 8'h00;

        // Reset state
        #12;
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'h00);
        chk("rst_imem_addr", {24'd0, imem_addr}, 32'h00);
        #10;
        rst_n = 1'b1;

        // Immediate then condition-always: 0, 1, then jump to 5
        wait_fetch(8'h00, "fetch0");
        wait_fetch(8'h01, "fetch1");
        wait_fetch(8'h05, "jump_to_5");

        // Build r1=3, r2=4, then compute
        wait_fetch(8'h06, "fetch6");
        wait_fetch(8'h07, "fetch7");
        wait_fetch(8'h08, "fetch8");
        wait_fetch(8'h09, "fetch9");
        chk("alu_op", {29'd0, alu_op}, 32'd4);
        chk("alu_a_r1", {24'd0, alu_a}, 32'd3);
        chk("alu_b_r2", {24'd0, alu_b}, 32'd4);
        wait_fetch(8'h0A, "fetch10");
        tick();
        chk("r3_out_valid", {31'd0, out_valid}, 32'd1);
        chk("r3_compute", {24'd0, out_data}, 32'd7);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("r3_out_done", {31'd0, out_valid}, 32'd0);

        // Input-to-output copy with delayed handshakes
        wait_fetch(8'h0B, "fetch_b6");
        tick();
        n_in = 0;
        for (int i = 0; i < 3; i++) begin
            if (in_ready) n_in++;
            tick();
        end
        in_valid = 1'b1;
        in_data  = 8'h5A;
        if (in_ready) n_in++;
        tick();
        in_valid = 1'b0;
        chk("in_ready_cycles", n_in, 32'd4);
        chk("in_ready_drop", {31'd0, in_ready}, 32'd0);
        n_out = 0;
        for (int i = 0; i < 2; i++) begin
            if (out_valid && out_data == 8'h5A) n_out++;
            tick();
        end
        out_ready = 1'b1;
        if (out_valid) n_out++;
        chk("io_out_data", {24'd0, out_data}, 32'h5A);
        tick();
        out_ready = 1'b0;
        chk("out_valid_cycles", n_out, 32'd3);
        chk("out_valid_drop", {31'd0, out_valid}, 32'd0);

        // r3 = 0x80 from the input port, then condition tests
        wait_fetch(8'h0C, "pc_after_io");
        in_valid = 1'b1;
        in_data  = 8'h80;
        tick();
        tick();
        in_valid = 1'b0;
        wait_fetch(8'h0D, "fetch_imm20");
        wait_fetch(8'h0E, "fetch_c2");
        wait_fetch(8'h20, "c2_less_jump");
        wait_fetch(8'h21, "c6_ge_fall");
        wait_fetch(8'h22, "fetch_c5");
        wait_fetch(8'h30, "c5_ne_jump");
        wait_fetch(8'h31, "c1_eq_fall");
        tick();
        chk("r3_is_80", {24'd0, out_data}, 32'h80);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // r0 = 0xFF, jump there, then wrap with two memory wait states
        wait_fetch(8'h32, "fetch_b0");
        in_valid = 1'b1;
        in_data  = 8'hFF;
        tick();
        tick();
        in_valid = 1'b0;
        wait_fetch(8'h33, "fetch_c4");
        wait_fetch(8'hFF, "jump_ff");
        ack_wait = 2;
        tick();
        chk("wait1_req", {31'd0, imem_req}, 32'd1);
        chk("wait1_ack", {31'd0, imem_ack}, 32'd0);
        chk("wrap_addr", {24'd0, imem_addr}, 32'h00);
        tick();
        chk("wait2_req", {31'd0, imem_req}, 32'd1);
        chk("wait2_addr", {24'd0, imem_addr}, 32'h00);
        wait_fetch(8'h00, "wrap_fetch");
        ack_wait = 0;

        // Rerun to WAIT_OUT, then reset mid-output
        seq = '{8'h01, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
        foreach (seq[i]) wait_fetch(seq[i], "rerun");
        tick();
        chk("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", {31'd0, out_valid}, 32'd0);
        chk("async_out_data", {24'd0, out_data}, 32'h00);
        chk("async_imem_req", {31'd0, imem_req}, 32'd0);
        #3;
        rst_n = 1'b1;
        mem[8'h00] = 8'hC0;
        wait_fetch(8'h00, "post_reset_addr");
        tick();
`ifdef OVERTURE_SEQ_HALT_EN
        chk("halted", {31'd0, halted}, 32'd1);
        n_req = 0;
        for (int i = 0; i < 5; i++) begin
            if (imem_req) n_req++;
            tick();
        end
        chk("halt_no_req", n_req, 32'd0);
        chk("halt_pc_frozen", {24'd0, imem_addr}, 32'h00);
`else
        n_req = 0;
        chk("halted_tied", {31'd0, halted}, 32'd0);
        wait_fetch(8'h01, "c0_nop");
        chk("nop_req_count", n_req, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/overture_sequencer.md
# overture_sequencer

Multi-cycle fetch/execute sequencer for the 8-bit Overture core. It owns the program counter and the six-entry register file (r0–r5). It decodes each instruction into immediate, compute, copy or condition, drives the external ALU, and performs ready/valid handshakes with program memory, the input port and the output port. For condition instructions it instantiates the condition evaluator, which tests r3 and decides whether to load r0 into the PC.

## Interface
- `RESET_PC`, default `8'h00`: PC value after reset.
- `clk` (in, 1): core clock; all state updates on the rising edge.
- `rst_n` (in, 1): reset, asynchronous and active-low.
- `imem_req` (out, 1): instruction fetch request.
- `imem_addr` (out, 8): fetch address; equals the PC.
- `imem_ack` (in, 1): `imem_data` is valid this cycle.
- `imem_data` (in, 8): instruction byte.
- `in_data` (in, 8): input port data.
- `in_valid` (in, 1): input port valid.
- `in_ready` (out, 1): sequencer accepts input.
- `out_data` (out, 8): output port data, registered.
- `out_valid` (out, 1): output port valid.
- `out_ready` (in, 1): output port sink ready.
- `alu_op` (out, 3): `instr[2:0]`.
- `alu_a` (out, 8): r1.
- `alu_b` (out, 8): r2.
- `alu_result` (in, 8): combinational result of the external ALU.
- `halted` (out, 1): sequencer is stopped; see Configuration.

## Operation
- States: FETCH, EXEC, WAIT_IN, WAIT_OUT, HALT.
- Reset values:
  - State FETCH; PC = `RESET_PC`.
  - r0–r5 = 0; `out_data` = 0.
  - `imem_req`, `in_ready`, `out_valid`, `halted` all 0. `imem_req` rises in the first cycle after reset release.
- FETCH:
  - `imem_req` = 1, `imem_addr` = PC.
  - On `imem_ack`, latch `imem_data` into the instruction register and go to EXEC.
- EXEC (one cycle), decoded on `instr[7:6]`:
  - `00` immediate: r0 <= {2'b00, `instr[5:0]`}; PC+1; go to FETCH.
  - `01` compute: r3 <= `alu_result`; PC+1; go to FETCH. The ALU ports are driven in every state; only this write is qualified.
  - `10` copy: src = `instr[5:3]`, dst = `instr[2:0]`. Indices 0–5 are registers, 6 is the I/O port, 7 is reserved.
    - src 6: go to WAIT_IN.
    - Otherwise, dst 6: out_data <= src value, go to WAIT_OUT.
    - Otherwise: dst <= src; PC+1; go to FETCH.
    - Reserved index: src 7 reads 0; a write to dst 7 is discarded.
  - `11` condition: `cond_sel` = `instr[2:0]`, evaluated on r3. If the condition is met, PC <= r0; otherwise PC+1. Go to FETCH.
- WAIT_IN:
  - `in_ready` = 1.
  - On `in_valid`, capture `in_data`.
  - If dst is 6: out_data <= captured value, go to WAIT_OUT.
  - Otherwise: write dst, PC+1, go to FETCH.
- WAIT_OUT:
  - `out_valid` = 1; `out_data` is held stable.
  - On `out_ready`: PC+1, go to FETCH.
- PC arithmetic is 8-bit modulo; 8'hFF+1 = 8'h00.
- A condition whose target is r0 = PC loops on itself; this is legal.
- `rst_n` asserted in any state aborts immediately: an in-flight fetch is abandoned, and a pending output is withdrawn with `out_valid` dropping asynchronously.

## Timing
- A fetch completes in the cycle where `imem_req && imem_ack`. A zero-wait memory gives a 2-cycle instruction (FETCH + EXEC).
- I/O copy instructions take 3 cycles minimum; a copy from port 6 to port 6 takes 4 cycles minimum.
- `in_ready` and `out_valid` are registered state decodes: a 0-cycle combinational path from state, with no input-to-output combinational path.
- `imem_req` is held until acked. `imem_addr` is stable while `imem_req` is high.
- A register written in EXEC is visible to the next instruction's EXEC.

## Configuration
- `OVERTURE_SEQ_HALT_EN` defined:
  - Instruction 8'hC0 (condition "never") enters HALT; `halted` = 1.
  - The PC is frozen at the address of the C0.
  - No further fetches until reset.
- Not defined: 8'hC0 is a NOP (PC+1), and `halted` is tied to 0.

## Structure
- Shared package `overture_pkg`:
  - State enum.
  - Opcode-class localparams (IMM, CALC, COPY, COND).
  - `IO_REG` = 6 and `RSVD_REG` = 7.
  - `HALT_INSTR` = 8'hC0.
- One sub-module: `overture_condition`, instantiated once.
  - Inputs: r3 and `instr[2:0]`.
  - Output: `cond_met`.

## Test plan
- Immediate then condition:
  - Stimulus: program 0x05, 0xC4 with `imem_ack` tied high.
  - Response: r0 = 5; the PC jumps to 5; `imem_addr` sequence 0, 1, 5.
- Compute:
  - Stimulus: r1 = 3, r2 = 4, instruction 0x44, `alu_result` = 7.
  - Response: r3 = 7 after EXEC; `alu_op` = 4.
- Input to output:
  - Stimulus: copy 0xB6 with `in_valid` delayed 3 cycles and `in_data` = 0x5A, then `out_ready` delayed 2 cycles.
  - Response: `in_ready` high for 4 cycles; `out_data` = 0x5A with `out_valid` high for 3 cycles; then the PC increments.
- Conditions on r3 = 0x80:
  - 0xC2 (less) jumps.
  - 0xC6 (greater_eq) falls through.
  - 0xC5 (not_eq) jumps.
  - 0xC1 (eq) falls through.
- PC wrap and memory wait states:
  - Stimulus: instruction 0x00 at PC = 0xFF; `imem_ack` delayed 2 cycles.
  - Response: the next `imem_addr` is 0x00; `imem_req` stays high through the wait.
- Halt and reset:
  - With `OVERTURE_SEQ_HALT_EN`, 0xC0 sets `halted` = 1 and no further `imem_req`.
  - Asserting `rst_n` low while in WAIT_OUT drops `out_valid` immediately; after release, `imem_addr` = 0x00.
